// File: rtl/flag_pwm.sv
// PWM generator advanced by an upstream tick enable, with a double-buffered
// period/duty config that takes effect only at period boundaries.
module flag_pwm #(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_DUTY   = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clk_flag,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             cfg_ready,
    output logic             pwm_out,
    output logic             period_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] per_pend;
    logic [CNT_W-1:0] duty_pend;
    logic             pend;

    logic active;
    logic take;
    logic wrap;

    assign cfg_ready = !pend;
    assign take      = cfg_valid && !pend;
    assign active    = (state != IDLE);
    // per_act is never 0 while active, so per_act-1 cannot underflow here
    assign wrap      = active && clk_flag && (cnt == per_act - CNT_ONE);

    // NOTE: all state lives in this one block and uses non-blocking
    // assignments, so every branch reads the pre-edge values of cnt/pend.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            per_act     <= CNT_W'(DEF_PERIOD);
            duty_act    <= CNT_W'(DEF_DUTY);
            per_pend    <= '0;
            duty_pend   <= '0;
            pend        <= 1'b0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            pwm_out     <= active && (cnt < duty_act);
            period_done <= wrap;

            if (take) begin
                per_pend  <= cfg_period;
                duty_pend <= cfg_duty;
                pend      <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // A waiting config is applied before any start decision
                    if (pend) begin
                        per_act  <= per_pend;
                        duty_act <= duty_pend;
                        pend     <= 1'b0;
                    end else if (run && per_act != '0) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN, STOP: begin
                    if (clk_flag) begin
                        cnt <= wrap ? '0 : cnt + CNT_ONE;
                    end
                    if (wrap && pend) begin
                        per_act  <= per_pend;
                        duty_act <= duty_pend;
                        pend     <= 1'b0;
                    end
                    if (state == RUN) begin
                        if (wrap && (!run || (pend && per_pend == '0))) begin
                            state <= IDLE;
                        end else if (!run) begin
                            state <= STOP;
                        end
                    end else begin
                        if (wrap) begin
                            state <= IDLE;
                        end else if (run) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_pwm.sv
// Self-checking bench for flag_pwm: a cycle model pushes expected outputs to
// a scoreboard queue, plus directed waveform counts over fixed windows.
module tb_flag_pwm;

    localparam int CNT_W = 8;

    typedef enum int {M_IDLE, M_RUN, M_STOP} m_state_t;

    typedef struct packed {
        logic ready;
        logic pwm;
        logic done;
    } exp_t;

    logic             sys_clk    = 1'b0;
    logic             sys_rst    = 1'b1;
    logic             clk_flag   = 1'b0;
    logic             run        = 1'b0;
    logic             cfg_valid  = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_duty   = '0;
    logic             cfg_ready;
    logic             pwm_out;
    logic             period_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t sb_q[$];

    m_state_t m_state;
    int       m_cnt, m_per, m_duty, m_pper, m_pduty;
    bit       m_pend;

    int flag_div   = 1;
    int flag_phase = 0;

    flag_pwm #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (10),
        .DEF_DUTY   (5)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .clk_flag    (clk_flag),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_ready   (cfg_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_per   = 10;
        m_duty  = 5;
        m_pper  = 0;
        m_pduty = 0;
        m_pend  = 1'b0;
    endtask

    // Computes what the DUT shows after the coming edge, given current inputs.
    task automatic model_step(output exp_t e);
        bit       running, wrap, take;
        m_state_t ns;
        int       nc, nper, nduty, npper, npduty;
        bit       npend;
        if (sys_rst) begin
            model_reset();
            e = '{1'b1, 1'b0, 1'b0};
            return;
        end
        running = (m_state != M_IDLE);
        wrap    = running && clk_flag && (m_cnt + 1 == m_per);
        take    = cfg_valid && !m_pend;
        e.pwm   = running && (m_cnt < m_duty);
        e.done  = wrap;
        ns = m_state; nc = m_cnt; nper = m_per; nduty = m_duty;
        npper = m_pper; npduty = m_pduty; npend = m_pend;
        if (m_state == M_IDLE) begin
            if (m_pend) begin
                nper = m_pper; nduty = m_pduty; npend = 1'b0;
            end else if (run && m_per != 0) begin
                ns = M_RUN; nc = 0;
            end
        end else begin
            if (clk_flag) nc = wrap ? 0 : m_cnt + 1;
            if (wrap && m_pend) begin
                nper = m_pper; nduty = m_pduty; npend = 1'b0;
            end
            if (m_state == M_RUN) begin
                if (wrap && (!run || nper == 0)) ns = M_IDLE;
                else if (!run)                   ns = M_STOP;
            end else begin
                if (wrap)     ns = M_IDLE;
                else if (run) ns = M_RUN;
            end
        end
        if (take) begin
            npper = int'(cfg_period); npduty = int'(cfg_duty); npend = 1'b1;
        end
        e.ready = !npend;
        m_state = ns; m_cnt = nc; m_per = nper; m_duty = nduty;
        m_pper = npper; m_pduty = npduty; m_pend = npend;
    endtask

    // One clock: derive clk_flag, predict, clock, then score the DUT.
    task automatic cycle();
        exp_t e;
        clk_flag = (flag_phase % flag_div == 0);
        flag_phase++;
        model_step(e);
        sb_q.push_back(e);
        @(posedge sys_clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("sb_ready", cfg_ready, e.ready);
        check("sb_pwm", pwm_out, e.pwm);
        check("sb_done", period_done, e.done);
    endtask

    task automatic window(input int n, output int hi, output int dn);
        hi = 0;
        dn = 0;
        repeat (n) begin
            cycle();
            hi += int'(pwm_out);
            dn += int'(period_done);
        end
    endtask

    task automatic wait_cnt(input int target, input int limit);
        int k;
        k = 0;
        while (!(m_state != M_IDLE && m_cnt == target) && k < limit) begin
            cycle();
            k++;
        end
        check($sformatf("reach_cnt%0d", target), (m_state != M_IDLE && m_cnt == target), 1);
    endtask

    task automatic offer(input int p, input int d);
        cfg_period = CNT_W'(p);
        cfg_duty   = CNT_W'(d);
        cfg_valid  = 1'b1;
        cycle();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        int hi, dn;
        model_reset();

        // Reset values while reset is held
        #1;
        check("rst_ready", cfg_ready, 1);
        check("rst_pwm", pwm_out, 0);
        check("rst_done", period_done, 0);
        repeat (2) cycle();
        sys_rst = 1'b0;

        // Defaults, tick every 5th clock: 25 high / 25 low, one done per 50
        run = 1'b1;
        flag_div = 5;
        flag_phase = 0;
        repeat (60) cycle();
        window(100, hi, dn);
        check("def_high", hi, 50);
        check("def_done", dn, 2);

        // Config 4/1 offered mid-period: held off until the wrap
        flag_div = 1;
        wait_cnt(3, 20);
        offer(4, 1);
        check("cfg_ready_low", cfg_ready, 0);
        repeat (12) cycle();
        window(40, hi, dn);
        check("p4d1_high", hi, 10);
        check("p4d1_done", dn, 10);

        // Duty 0 never high; duty above period always high
        offer(10, 0);
        repeat (12) cycle();
        window(30, hi, dn);
        check("duty0_high", hi, 0);
        check("duty0_done", dn, 3);
        offer(10, 12);
        repeat (12) cycle();
        window(30, hi, dn);
        check("duty12_high", hi, 30);
        check("duty12_done", dn, 3);

        // run dropped at count 3: period completes, then idle
        offer(10, 5);
        repeat (12) cycle();
        wait_cnt(3, 20);
        run = 1'b0;
        window(15, hi, dn);
        check("stop_done", dn, 1);
        check("stop_pwm_low", pwm_out, 0);

        // run dropped at 3 and re-raised at 7: uninterrupted waveform
        run = 1'b1;
        wait_cnt(3, 20);
        run = 1'b0;
        wait_cnt(7, 20);
        run = 1'b1;
        window(30, hi, dn);
        check("rerun_high", hi, 15);
        check("rerun_done", dn, 3);

        // Period 0 applied on the wrap: parks in IDLE despite run=1
        offer(0, 3);
        repeat (12) cycle();
        window(30, hi, dn);
        check("per0_high", hi, 0);
        check("per0_done", dn, 0);

        // Async reset mid-high-phase with a config pending
        offer(10, 5);
        wait_cnt(2, 20);
        offer(4, 1);
        check("pre_rst_pwm", pwm_out, 1);
        check("pre_rst_ready", cfg_ready, 0);
        #2;
        sys_rst = 1'b1;
        #1;
        model_reset();
        check("arst_pwm", pwm_out, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_done", period_done, 0);
        repeat (2) cycle();
        sys_rst = 1'b0;
        repeat (5) cycle();
        window(40, hi, dn);
        check("post_rst_high", hi, 20);
        check("post_rst_done", dn, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
